// File: rtl/mos6502s_indirect_fetch_seq_if.sv
// Bus bundle for the 6502 indirect-operand fetch sequencer: request, memory read port and result.
// master = requester plus memory side; slave = the sequencer.
interface mos6502s_indirect_fetch_seq_if;
  logic        start;
  logic [3:0]  mode;
  logic [7:0]  operand_lo;
  logic [7:0]  operand_hi;
  logic [7:0]  x_reg;
  logic [7:0]  y_reg;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        done;
  logic [15:0] eff_addr;
  logic        page_cross;
  logic        err;

  modport master (
    output start, mode, operand_lo, operand_hi, x_reg, y_reg, mem_ready, mem_rdata,
    input  mem_rd, mem_addr, busy, done, eff_addr, page_cross, err
  );

  modport slave (
    input  start, mode, operand_lo, operand_hi, x_reg, y_reg, mem_ready, mem_rdata,
    output mem_rd, mem_addr, busy, done, eff_addr, page_cross, err
  );
endinterface

// File: rtl/mos6502s_indirect_fetch_seq.sv
// Resolves (abs), (zp,X) and (zp),Y operands by reading the 16-bit pointer from memory.
// Optional macro MOS6502S_CMOS_JMP_FIX_EN selects 65C02 JMP (abs) page-crossing behaviour.
module mos6502s_indirect_fetch_seq (
  input  logic                              clk,
  input  logic                              rst,
  mos6502s_indirect_fetch_seq_if.slave      bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_LO  = 3'd1;
  localparam logic [2:0] RD_HI  = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
`ifdef MOS6502S_CMOS_JMP_FIX_EN
  localparam logic [2:0] RD_GAP = 3'd4;
`endif

  localparam logic [3:0] MODE_JMP = 4'd9;
  localparam logic [3:0] MODE_IZX = 4'd10;
  localparam logic [3:0] MODE_IZY = 4'd11;

  logic [2:0]  state_reg, state_next;
  logic [3:0]  mode_reg;
  logic [7:0]  lo_reg, hi_reg, idx_x_reg, idx_y_reg;
  logic [7:0]  lo_byte_reg;
  logic [15:0] eff_addr_reg;
  logic        page_cross_reg, err_reg;

  logic        mode_valid;
  logic [7:0]  zp_base, zp_base_inc, lo_inc;
  logic [15:0] ptr_lo, ptr_hi;
  logic [15:0] ptr_data;
  logic [8:0]  lo_sum;

  assign mode_valid = (bus.mode == MODE_JMP) || (bus.mode == MODE_IZX) || (bus.mode == MODE_IZY);

  assign zp_base     = lo_reg + idx_x_reg;
  assign zp_base_inc = zp_base + 8'd1;
  assign lo_inc      = lo_reg + 8'd1;

  always_comb begin
    ptr_lo = {8'h00, lo_reg};
    ptr_hi = {8'h00, lo_inc};
    case (mode_reg)
      MODE_JMP: begin
        ptr_lo = {hi_reg, lo_reg};
`ifdef MOS6502S_CMOS_JMP_FIX_EN
        ptr_hi = {hi_reg, lo_reg} + 16'd1;
`else
        // NMOS quirk: the increment never carries into the page byte
        ptr_hi = {hi_reg, lo_inc};
`endif
      end
      MODE_IZX: begin
        ptr_lo = {8'h00, zp_base};
        ptr_hi = {8'h00, zp_base_inc};
      end
      default: begin
        ptr_lo = {8'h00, lo_reg};
        ptr_hi = {8'h00, lo_inc};
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (bus.start) state_next = mode_valid ? RD_LO : DONE;
      RD_LO: begin
        if (bus.mem_ready) begin
`ifdef MOS6502S_CMOS_JMP_FIX_EN
          state_next = (mode_reg == MODE_JMP && lo_reg == 8'hFF) ? RD_GAP : RD_HI;
`else
          state_next = RD_HI;
`endif
        end
      end
`ifdef MOS6502S_CMOS_JMP_FIX_EN
      RD_GAP: state_next = RD_HI;
`endif
      RD_HI: if (bus.mem_ready) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ptr_data = {bus.mem_rdata, lo_byte_reg};
  assign lo_sum   = {1'b0, lo_byte_reg} + {1'b0, idx_y_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      mode_reg       <= 4'd0;
      lo_reg         <= 8'd0;
      hi_reg         <= 8'd0;
      idx_x_reg      <= 8'd0;
      idx_y_reg      <= 8'd0;
      lo_byte_reg    <= 8'd0;
      eff_addr_reg   <= 16'd0;
      page_cross_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && bus.start) begin
        mode_reg  <= bus.mode;
        lo_reg    <= bus.operand_lo;
        hi_reg    <= bus.operand_hi;
        idx_x_reg <= bus.x_reg;
        idx_y_reg <= bus.y_reg;
        err_reg   <= !mode_valid;
        if (!mode_valid) begin
          eff_addr_reg   <= 16'd0;
          page_cross_reg <= 1'b0;
        end
      end
      if (state_reg == RD_LO && bus.mem_ready) lo_byte_reg <= bus.mem_rdata;
      if (state_reg == RD_HI && bus.mem_ready) begin
        if (mode_reg == MODE_IZY) begin
          eff_addr_reg   <= ptr_data + {8'h00, idx_y_reg};
          page_cross_reg <= lo_sum[8];
        end else begin
          eff_addr_reg   <= ptr_data;
          page_cross_reg <= 1'b0;
        end
      end
    end
  end

  // Address is forced to zero outside the read states so reset drops it immediately
  assign bus.mem_rd     = (state_reg == RD_LO) || (state_reg == RD_HI);
  assign bus.mem_addr   = (state_reg == RD_LO) ? ptr_lo :
                          (state_reg == RD_HI) ? ptr_hi : 16'd0;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE);
  assign bus.err        = (state_reg == DONE) && err_reg;
  assign bus.eff_addr   = eff_addr_reg;
  assign bus.page_cross = page_cross_reg;

endmodule

// File: tb/tb_mos6502s_indirect_fetch_seq.sv
// Self-checking bench for mos6502s_indirect_fetch_seq: directed vector table, reset corner cases, random runs.
module tb_mos6502s_indirect_fetch_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mos6502s_indirect_fetch_seq_if bus();

  mos6502s_indirect_fetch_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:65535];
  assign bus.mem_rdata = mem[bus.mem_addr];

  // memory wait-state generator and read logger
  int w_lo = 0, w_hi = 0;
  int wcnt = 0, rd_idx = 0, nreads = 0, unstable = 0;
  logic [15:0] rd_log [0:3];
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr = 16'd0;

  assign bus.mem_ready = (wcnt >= ((rd_idx == 0) ? w_lo : w_hi));

  always @(posedge clk) begin
    if (!bus.busy && bus.start) nreads <= 0;
    else if (bus.mem_rd && bus.mem_ready) begin
      if (nreads < 4) rd_log[nreads] <= bus.mem_addr;
      nreads <= nreads + 1;
    end
    if (!rst && prev_wait && (!bus.mem_rd || bus.mem_addr != prev_addr)) unstable <= unstable + 1;
    prev_wait <= !rst && bus.mem_rd && !bus.mem_ready;
    prev_addr <= bus.mem_addr;
    if (!bus.busy) begin
      rd_idx <= 0;
      wcnt   <= 0;
    end else if (bus.mem_rd && bus.mem_ready) begin
      rd_idx <= rd_idx + 1;
      wcnt   <= 0;
    end else if (bus.mem_rd) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  typedef struct {
    logic [3:0] mode;
    logic [7:0] lo, hi, x, y;
    int w_lo, w_hi;
    bit poke;
    int exp_n, exp_rd0, exp_rd1, exp_eff, exp_pc, exp_err, exp_cyc;
  } vec_t;

  int n_chk = 0, n_pass = 0, n_txn = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: pointer rules and timing taken directly from the addressing-mode definitions
  task automatic model(inout vec_t v);
    int p0, p1, b0, b1, base;
    bit fix;
`ifdef MOS6502S_CMOS_JMP_FIX_EN
    fix = 1'b1;
`else
    fix = 1'b0;
`endif
    v.exp_pc = 0; v.exp_eff = 0; v.exp_rd0 = 0; v.exp_rd1 = 0;
    if (!(v.mode == 9 || v.mode == 10 || v.mode == 11)) begin
      v.exp_n = 0; v.exp_err = 1; v.exp_cyc = 1;
      return;
    end
    if (v.mode == 9) begin
      p0 = v.hi * 256 + v.lo;
      p1 = fix ? (p0 + 1) % 65536 : v.hi * 256 + (v.lo + 1) % 256;
    end else if (v.mode == 10) begin
      p0 = (v.lo + v.x) % 256;
      p1 = (v.lo + v.x + 1) % 256;
    end else begin
      p0 = v.lo;
      p1 = (v.lo + 1) % 256;
    end
    b0 = mem[p0]; b1 = mem[p1];
    base = b1 * 256 + b0;
    v.exp_rd0 = p0; v.exp_rd1 = p1; v.exp_n = 2; v.exp_err = 0;
    if (v.mode == 11) begin
      v.exp_eff = (base + v.y) % 65536;
      v.exp_pc  = (b0 + v.y > 255) ? 1 : 0;
    end else v.exp_eff = base;
    v.exp_cyc = 3 + v.w_lo + v.w_hi + ((fix && v.mode == 9 && v.lo == 8'hFF) ? 1 : 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    bit seen;
    int got_err, got_eff, got_pc;
    w_lo = v.w_lo; w_hi = v.w_hi;
    bus.start = 1'b1; bus.mode = v.mode; bus.operand_lo = v.lo; bus.operand_hi = v.hi;
    bus.x_reg = v.x; bus.y_reg = v.y;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 60) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (v.poke && cyc == 2) begin
          bus.start = 1'b1; bus.mode = 4'd10; bus.operand_lo = 8'h77; bus.operand_hi = 8'h55;
          bus.x_reg = 8'h03; bus.y_reg = 8'h09;
        end else bus.start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    got_err = bus.err; got_eff = bus.eff_addr; got_pc = bus.page_cross;
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " cycles"}, cyc, v.exp_cyc);
    chk({tag, " err"}, got_err, v.exp_err);
    chk({tag, " nreads"}, nreads, v.exp_n);
    if (v.exp_n == 2) begin
      chk({tag, " rd0"}, rd_log[0], v.exp_rd0);
      chk({tag, " rd1"}, rd_log[1], v.exp_rd1);
      chk({tag, " eff_addr"}, got_eff, v.exp_eff);
      chk({tag, " page_cross"}, got_pc, v.exp_pc);
    end
    // a start presented during the DONE cycle must not launch a new request
    bus.start = 1'b1; bus.mode = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, " done_pulse"}, bus.done, 0);
    chk({tag, " idle_after"}, bus.busy, 0);
    n_txn++;
    $display("txn %0d %s mode=%0d lo=%02h hi=%02h x=%02h y=%02h waits=%0d/%0d eff=%04h pc=%0d err=%0d cyc=%0d",
             n_txn, tag, v.mode, v.lo, v.hi, v.x, v.y, v.w_lo, v.w_hi, got_eff, got_pc, got_err, cyc);
  endtask

  vec_t vecs [0:6];
  vec_t v;
  bit   done_flag;
  int   k;

  initial begin
    bus.start = 1'b0; bus.mode = 4'd0; bus.operand_lo = 8'd0; bus.operand_hi = 8'd0;
    bus.x_reg = 8'd0; bus.y_reg = 8'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h12FF] = 8'h34; mem[16'h1200] = 8'h56; mem[16'h1300] = 8'h78;
    mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h20;
    mem[16'h0040] = 8'hF8; mem[16'h0041] = 8'h12;

    //          mode  lo     hi     x      y      wl wh poke n  rd0      rd1      eff      pc err cyc
`ifdef MOS6502S_CMOS_JMP_FIX_EN
    vecs[0] = '{4'd9, 8'hFF, 8'h12, 8'h00, 8'h00, 0, 0, 0, 2, 'h12FF, 'h1300, 'h7834, 0, 0, 4};
`else
    vecs[0] = '{4'd9, 8'hFF, 8'h12, 8'h00, 8'h00, 0, 0, 0, 2, 'h12FF, 'h1200, 'h5634, 0, 0, 3};
`endif
    vecs[1] = '{4'd10, 8'hFE, 8'h00, 8'h01, 8'h00, 0, 0, 0, 2, 'h00FF, 'h0000, 'h2000, 0, 0, 3};
    vecs[2] = '{4'd11, 8'h40, 8'h00, 8'h00, 8'h10, 0, 0, 0, 2, 'h0040, 'h0041, 'h1308, 1, 0, 3};
    vecs[3] = '{4'd11, 8'h40, 8'h00, 8'h00, 8'h10, 2, 2, 1, 2, 'h0040, 'h0041, 'h1308, 1, 0, 7};
    vecs[4] = '{4'd5,  8'h40, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0, 0,       0,       0,       0, 1, 1};
    vecs[5] = '{4'd9,  8'h40, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2, 'h0040, 'h0041, 'h12F8, 0, 0, 3};
    vecs[6] = '{4'd11, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0, 0, 2, 'h00FF, 'h0000, 'h2000, 0, 0, 4};

    #2;
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst mem_rd", bus.mem_rd, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst eff_addr", bus.eff_addr, 0);
    chk("rst page_cross", bus.page_cross, 0);
    chk("rst err", bus.err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("dir%0d", i));

    // reset while waiting in RD_HI
    w_lo = 0; w_hi = 30;
    bus.start = 1'b1; bus.mode = 4'd11; bus.operand_lo = 8'h40; bus.y_reg = 8'h10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    while (!(bus.mem_rd && nreads == 1) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("arst reach_rd_hi", (bus.mem_rd && nreads == 1) ? 1 : 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst mem_rd", bus.mem_rd, 0);
    chk("arst busy", bus.busy, 0);
    chk("arst mem_addr", bus.mem_addr, 0);
    chk("arst eff_addr", bus.eff_addr, 0);
    done_flag = 1'b0;
    @(posedge clk); #1;
    done_flag |= bus.done;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      done_flag |= bus.done;
    end
    chk("arst no_done", done_flag, 0);
    chk("arst idle", bus.busy, 0);
    run_vec(vecs[2], "post_rst");

    // randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      int r, m;
      r = $urandom_range(0, 4);
      v.lo = 8'($urandom); v.hi = 8'($urandom); v.x = 8'($urandom); v.y = 8'($urandom);
      if (r <= 2) v.mode = 4'(9 + r);
      else if (r == 3) begin
        v.mode = 4'd9; v.lo = 8'hFF;
      end else begin
        m = $urandom_range(0, 12);
        if (m >= 9) m += 3;
        v.mode = 4'(m);
      end
      v.w_lo = $urandom_range(0, 2); v.w_hi = $urandom_range(0, 2);
      v.poke = ($urandom_range(0, 3) == 0);
      model(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    chk("addr stable during waits", unstable, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mos6502s_indirect_fetch_seq.md
MOS6502S_INDIRECT_FETCH_SEQ -- requirements
Module: mos6502s_indirect_fetch_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request to resolve one indirect operand; sampled only in IDLE.
REQ-005 mode  in  4  addressing mode: 9 = (abs) JMP, 10 = (zp,X), 11 = (zp),Y; others invalid.
REQ-006 operand_lo / operand_hi  in  8 each  instruction operand bytes.
REQ-007 x_reg / y_reg  in  8 each  index registers.
REQ-008 mem_rd  out  1  memory read request.
REQ-009 mem_addr  out  16  read address, valid while mem_rd=1.
REQ-010 mem_ready  in  1  read completes on a rising edge where mem_rd=1 and mem_ready=1.
REQ-011 mem_rdata  in  8  read data, valid when mem_ready=1.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  one-cycle pulse; eff_addr, page_cross and err are valid.
REQ-014 eff_addr  out  16  resolved effective address; held until the next accepted start.
REQ-015 page_cross  out  1  (zp),Y indexing carried into the high byte.
REQ-016 err  out  1  qualifies done; the request had an invalid mode.

Function
REQ-017 FSM states SHALL be IDLE, RD_LO, RD_HI and DONE.
REQ-018 In IDLE with start=1, the block SHALL latch mode, operands, x_reg and y_reg.
- Valid mode: next state RD_LO.
- Invalid mode: next state DONE with err=1; no memory access.
REQ-019 The pointer addresses SHALL be computed from latched values:
- mode 9: ptr_lo = {hi,lo}; ptr_hi = {hi,lo}+1, except when lo=FF, where ptr_hi = {hi,00} (page-wrap bug).
- mode 10: ptr_lo = {00,(lo+X) mod 256}; ptr_hi = {00,(lo+X+1) mod 256}.
- mode 11: ptr_lo = {00,lo}; ptr_hi = {00,(lo+1) mod 256}.
REQ-020 RD_LO SHALL assert mem_rd=1 with mem_addr=ptr_lo and hold both until mem_ready=1, then capture mem_rdata as the low byte and go to RD_HI.
REQ-021 RD_HI SHALL do the same with ptr_hi, capturing the high byte, then go to DONE.
REQ-022 eff_addr SHALL be loaded on entry to DONE:
- modes 9 and 10: eff_addr = {hi_byte, lo_byte}.
- mode 11: eff_addr = ({hi_byte, lo_byte} + Y) mod 65536; page_cross = 1 when lo_byte + Y > 255.
- page_cross = 0 in all other modes.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-024 start while busy=1 SHALL be ignored, with no change to the latched inputs.
REQ-025 With mem_ready tied high, done SHALL assert 3 cycles after the accepted start edge; each wait cycle adds 1 cycle.
REQ-026 mem_rd SHALL be low in IDLE and DONE.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, mem_rd=0, mem_addr=0, busy=0, done=0, eff_addr=0, page_cross=0 and err=0, including in the middle of an operation.
REQ-028 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-029 With macro MOS6502S_CMOS_JMP_FIX_EN defined, mode 9 with lo=FF SHALL use ptr_hi = {hi,lo}+1 (65C02 behaviour) and SHALL insert one extra idle cycle between RD_LO and RD_HI (done at 4 cycles with ready tied high).
REQ-030 With MOS6502S_CMOS_JMP_FIX_EN undefined, REQ-019 and REQ-025 SHALL apply unchanged.

Verification
REQ-031 mode=9, operand 0x12FF, memory [12FF]=34, [1200]=56, [1300]=78, ready high -> reads at 12FF then 1200, eff_addr=5634, done at cycle 3; with the macro defined -> reads at 12FF then 1300, eff_addr=7834, done at cycle 4.
REQ-032 mode=10, lo=FE, X=01, [00FF]=00, [0000]=20 -> reads at 00FF then 0000, eff_addr=2000.
REQ-033 mode=11, lo=40, Y=10, [0040]=F8, [0041]=12 -> eff_addr=1308, page_cross=1.
REQ-034 mode=11 with mem_ready low for 2 cycles in each read state -> mem_addr stable during the waits, done at cycle 7, and a second start pulsed while busy is ignored.
REQ-035 mode=5 -> done and err pulse at cycle 1, mem_rd never asserts; rst asserted during RD_HI -> mem_rd and busy drop without waiting for a clock edge, and done is never produced.
